parking_occupancy_tracker: RTL and testbench
============================================

Name: parking_occupancy_tracker

Overview:
Downstream of the parking-lot sensor FSM, this block consumes its `enter`/`exit` event outputs and maintains the number of cars currently in the lot. It saturates at a configurable capacity and raises full/empty status. It also keeps a two-digit BCD copy of the occupancy for the seven-segment display driver.

Parameters:
CAPACITY, 20, maximum occupancy; legal range 1..99.
WIDTH, 7, width of binary count; must satisfy 2^WIDTH > CAPACITY.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear of count and error flag
enter  input  1  car-entered event from sensor FSM (level or pulse)
exit  input  1  car-exited event from sensor FSM (level or pulse)
count  output  WIDTH  current occupancy, binary
bcd_tens  output  4  occupancy tens digit, 0..9
bcd_ones  output  4  occupancy ones digit, 0..9
full  output  1  high when count == CAPACITY
empty  output  1  high when count == 0
reject  output  1  one-cycle pulse: entry attempted while full
err_underflow  output  1  sticky: exit seen while empty

Behaviour:
- Reset (rst=1, asynchronous):
  - count=0, bcd_tens=0, bcd_ones=0, full=0, empty=1, reject=0, err_underflow=0.
  - Edge-detect registers enter_q=0 and exit_q=0.
- Event detection:
  - inc_ev = enter & ~enter_q; dec_ev = exit & ~exit_q.
  - enter_q/exit_q are registered copies of the inputs.
  - A held-high input therefore produces exactly one event.
  - An input already high on the first cycle after reset counts as one event.
- Update priority, evaluated each rising edge:
  1. clr=1: count=0, BCD=00, err_underflow=0, reject=0. Events in that cycle are discarded; enter_q/exit_q still update.
  2. inc_ev & dec_ev: no change to count or BCD (net zero). No reject or underflow, even if full/empty.
  3. inc_ev only, count<CAPACITY: count+1 and BCD+1. On BCD, ones 9 -> 0 carries into tens.
  4. inc_ev only, count==CAPACITY: count held; reject=1 for exactly one cycle.
  5. dec_ev only, count>0: count-1 and BCD-1. On BCD, ones 0 -> 9 borrows from tens.
  6. dec_ev only, count==0: count held at 0 (no wrap); err_underflow set to 1 and held until clr or rst.
  7. Otherwise: hold; reject=0.
- Latency:
  - count/BCD/full/empty reflect an event on the rising edge after the cycle in which the input is first sampled high. That is 1 clk of latency.
  - full/empty are registered and consistent with count in the same cycle, never a cycle late.
- Consistency invariant, checked every cycle: bcd_tens*10 + bcd_ones == count, and bcd_ones <= 9.
- BCD is maintained incrementally, as up/down decade counters. It is not derived by division.
- Reset asserted mid-sequence forces reset values immediately, independent of clk. The first edge after release behaves as after power-up.
- Structure:
  - 3-state control FSM: EMPTY (count==0), PARTIAL, FULL (count==CAPACITY). State encodes full/empty.
  - Transitions:
    - EMPTY -> PARTIAL on legal inc.
    - PARTIAL -> FULL when inc brings count to CAPACITY.
    - FULL -> PARTIAL on dec.
    - PARTIAL -> EMPTY when dec brings count to 0.
    - Any state -> EMPTY on clr.
  - CAPACITY=1 goes EMPTY <-> FULL directly.

Test Plan:
- Reset then 3 single-cycle enter pulses, 10 cycles apart -> count 1,2,3 each 1 clk after its pulse; BCD 0/3; empty falls after first pulse; full=0.
- enter held high 50 cycles -> count increments once only (0 -> 1); reject stays 0.
- CAPACITY=20: 21 enter pulses -> count=20, BCD 2/0, full=1 after 20th; 21st gives reject=1 for one cycle and count stays 20; one exit -> count=19, BCD 1/9, full=0.
- From count=9, enter -> BCD 1/0 (carry); exit -> BCD 0/9 (borrow); invariant holds every cycle.
- From reset, exit pulse -> count stays 0, empty=1, err_underflow=1 and stays 1; then clr=1 for one cycle -> err_underflow=0, count=0.
- Simultaneous rising enter & exit at count=5 -> count stays 5. Then rst asserted between clk edges at count=5 -> count=0, empty=1 immediately, before the next edge.

Source files
------------

// File: rtl/parking_occupancy_tracker.sv
// Parking-lot occupancy counter fed by enter/exit events, with saturating binary count,
// incrementally maintained two-digit BCD copy, full/empty status, reject pulse and sticky underflow.
module parking_occupancy_tracker #(
    parameter int unsigned CAPACITY = 20,
    parameter int unsigned WIDTH    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             enter,
    input  logic             exit,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             full,
    output logic             empty,
    output logic             reject,
    output logic             err_underflow
);

    // State encoding carries the status directly: bit1 = full, bit0 = empty.
    localparam logic [1:0] ST_PARTIAL = 2'b00;
    localparam logic [1:0] ST_EMPTY   = 2'b01;
    localparam logic [1:0] ST_FULL    = 2'b10;

    localparam logic [WIDTH-1:0] CAP_M1 = WIDTH'(CAPACITY - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_reject;
    logic             r_err;
    logic             r_enter_q;
    logic             r_exit_q;

    logic [1:0]       w_state_nx;
    logic [WIDTH-1:0] w_count_nx;
    logic [3:0]       w_tens_nx;
    logic [3:0]       w_ones_nx;
    logic             w_reject_nx;
    logic             w_err_nx;
    logic             w_inc_ev;
    logic             w_dec_ev;

    assign w_inc_ev = enter & ~r_enter_q;
    assign w_dec_ev = exit  & ~r_exit_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_count   <= '0;
            r_tens    <= 4'd0;
            r_ones    <= 4'd0;
            r_reject  <= 1'b0;
            r_err     <= 1'b0;
            r_enter_q <= 1'b0;
            r_exit_q  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_tens    <= w_tens_nx;
            r_ones    <= w_ones_nx;
            r_reject  <= w_reject_nx;
            r_err     <= w_err_nx;
            r_enter_q <= enter;
            r_exit_q  <= exit;
        end
    end

    // Next-state and datapath update in priority order: clear, net-zero, inc, dec.
    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_tens_nx   = r_tens;
        w_ones_nx   = r_ones;
        w_reject_nx = 1'b0;
        w_err_nx    = r_err;

        if (clr) begin
            w_state_nx = ST_EMPTY;
            w_count_nx = '0;
            w_tens_nx  = 4'd0;
            w_ones_nx  = 4'd0;
            w_err_nx   = 1'b0;
        end else if (w_inc_ev && !w_dec_ev) begin
            if (r_state == ST_FULL) begin
                w_reject_nx = 1'b1;
            end else begin
                w_count_nx = r_count + WIDTH'(1);
                if (r_ones == 4'd9) begin
                    w_ones_nx = 4'd0;
                    w_tens_nx = r_tens + 4'd1;
                end else begin
                    w_ones_nx = r_ones + 4'd1;
                end
                w_state_nx = (r_count == CAP_M1) ? ST_FULL : ST_PARTIAL;
            end
        end else if (w_dec_ev && !w_inc_ev) begin
            if (r_state == ST_EMPTY) begin
                w_err_nx = 1'b1;
            end else begin
                w_count_nx = r_count - WIDTH'(1);
                if (r_ones == 4'd0) begin
                    w_ones_nx = 4'd9;
                    w_tens_nx = r_tens - 4'd1;
                end else begin
                    w_ones_nx = r_ones - 4'd1;
                end
                w_state_nx = (r_count == WIDTH'(1)) ? ST_EMPTY : ST_PARTIAL;
            end
        end
    end

    assign count         = r_count;
    assign bcd_tens      = r_tens;
    assign bcd_ones      = r_ones;
    assign full          = r_state[1];
    assign empty         = r_state[0];
    assign reject        = r_reject;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Bench for parking_occupancy_tracker: vector table, directed corner sequences and
// randomized traffic, all compared against an occupancy model kept in the bench.
module tb_parking_occupancy_tracker;

    localparam int unsigned CAP = 20;
    localparam int unsigned W   = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         enter = 1'b0;
    logic         exit = 1'b0;
    logic [W-1:0] count;
    logic [3:0]   bcd_tens;
    logic [3:0]   bcd_ones;
    logic         full;
    logic         empty;
    logic         reject;
    logic         err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_occ;
    bit m_pe, m_px, m_err, m_rej;

    typedef struct {
        bit en, ex, cl;
        int exp_count;
        bit exp_rej;
        bit exp_err;
    } vec_t;

    vec_t vecs[16];

    parking_occupancy_tracker #(.CAPACITY(CAP), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .enter(enter), .exit(exit),
        .count(count), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
        .full(full), .empty(empty), .reject(reject), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_pe = 0; m_px = 0; m_err = 0; m_rej = 0;
    endtask

    task automatic model_step(input bit en, input bit ex, input bit cl);
        bit inc, dec;
        inc = en && !m_pe;
        dec = ex && !m_px;
        m_pe = en;
        m_px = ex;
        m_rej = 0;
        if (cl) begin
            m_occ = 0;
            m_err = 0;
        end else if (inc && !dec) begin
            if (m_occ < int'(CAP)) m_occ++;
            else m_rej = 1;
        end else if (dec && !inc) begin
            if (m_occ > 0) m_occ--;
            else m_err = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},  int'(count), m_occ);
        chk({tag, ".tens"},   int'(bcd_tens), m_occ / 10);
        chk({tag, ".ones"},   int'(bcd_ones), m_occ % 10);
        chk({tag, ".full"},   int'(full), int'(m_occ == int'(CAP)));
        chk({tag, ".empty"},  int'(empty), int'(m_occ == 0));
        chk({tag, ".reject"}, int'(reject), int'(m_rej));
        chk({tag, ".err"},    int'(err_underflow), int'(m_err));
    endtask

    // Called at posedge+1; returns at the following posedge+1 with outputs checked.
    task automatic step(input bit en, input bit ex, input bit cl, input string tag);
        enter = en; exit = ex; clr = cl;
        model_step(en, ex, cl);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_enter(input string tag);
        step(1, 0, 0, tag);
        step(0, 0, 0, tag);
    endtask

    task automatic pulse_exit(input string tag);
        step(0, 1, 0, tag);
        step(0, 0, 0, tag);
    endtask

    task automatic do_reset();
        enter = 0; exit = 0; clr = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        // {en, ex, cl, count, reject, err}
        vecs[0]  = '{1, 0, 0, 1, 0, 0};
        vecs[1]  = '{1, 0, 0, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 0, 0};
        vecs[3]  = '{1, 0, 0, 2, 0, 0};
        vecs[4]  = '{0, 1, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 0, 0};
        vecs[6]  = '{0, 1, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 1, 0, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 1};
        vecs[10] = '{1, 1, 0, 0, 0, 1};
        vecs[11] = '{0, 0, 1, 0, 0, 0};
        vecs[12] = '{1, 0, 1, 0, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0};
        vecs[15] = '{1, 0, 0, 1, 0, 0};

        @(posedge clk);
        #1;
        chk("rst.count", int'(count), 0);
        chk("rst.empty", int'(empty), 1);
        chk("rst.full", int'(full), 0);
        do_reset();

        // Vector table from reset; enter already high on the first cycle counts.
        for (int i = 0; i < 16; i++) begin
            enter = vecs[i].en; exit = vecs[i].ex; clr = vecs[i].cl;
            model_step(vecs[i].en, vecs[i].ex, vecs[i].cl);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d.reject", i), int'(reject), int'(vecs[i].exp_rej));
            chk($sformatf("vec%0d.err", i), int'(err_underflow), int'(vecs[i].exp_err));
            check_all($sformatf("vec%0d", i));
        end

        // Three pulses ten cycles apart.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            step(1, 0, 0, "pulse");
            chk("pulse.count", int'(count), p + 1);
            for (int c = 0; c < 9; c++) step(0, 0, 0, "pulse_gap");
        end
        chk("pulse.ones", int'(bcd_ones), 3);

        // Enter held for 50 cycles counts once.
        do_reset();
        for (int c = 0; c < 50; c++) step(1, 0, 0, "held");
        chk("held.count", int'(count), 1);
        step(0, 0, 0, "held_rel");

        // Fill to capacity, one rejected entry, then one exit.
        do_reset();
        for (int p = 0; p < int'(CAP); p++) pulse_enter("fill");
        chk("fill.full", int'(full), 1);
        chk("fill.tens", int'(bcd_tens), 2);
        step(1, 0, 0, "over");
        chk("over.reject", int'(reject), 1);
        chk("over.count", int'(count), int'(CAP));
        step(0, 0, 0, "over_clear");
        chk("over.reject_gone", int'(reject), 0);
        pulse_exit("drain1");
        chk("drain1.count", int'(count), int'(CAP) - 1);
        chk("drain1.ones", int'(bcd_ones), 9);

        // Carry and borrow around 9/10.
        do_reset();
        for (int p = 0; p < 9; p++) pulse_enter("to9");
        pulse_enter("carry");
        chk("carry.tens", int'(bcd_tens), 1);
        chk("carry.ones", int'(bcd_ones), 0);
        pulse_exit("borrow");
        chk("borrow.tens", int'(bcd_tens), 0);
        chk("borrow.ones", int'(bcd_ones), 9);

        // Underflow is sticky until clr.
        do_reset();
        pulse_exit("uflow");
        for (int c = 0; c < 5; c++) step(0, 0, 0, "uflow_hold");
        chk("uflow.err", int'(err_underflow), 1);
        step(0, 0, 1, "uflow_clr");
        chk("uflow_clr.err", int'(err_underflow), 0);
        step(0, 0, 0, "after_clr");

        // Simultaneous enter/exit at 5, then asynchronous reset between edges.
        do_reset();
        for (int p = 0; p < 5; p++) pulse_enter("to5");
        step(1, 1, 0, "both");
        chk("both.count", int'(count), 5);
        step(0, 0, 0, "both_rel");
        #2;
        rst = 1;
        #1;
        chk("async.count", int'(count), 0);
        chk("async.empty", int'(empty), 1);
        chk("async.tens", int'(bcd_tens), 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check_all("async_rel");

        // Randomized traffic: entry-heavy, exit-heavy, then mixed with rare clears.
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 600; c++) begin
                bit en, ex, cl;
                en = ($urandom_range(99) < ((ph == 1) ? 20 : 60));
                ex = ($urandom_range(99) < ((ph == 0) ? 20 : 55));
                cl = (ph == 2) && ($urandom_range(199) == 0);
                step(en, ex, cl, $sformatf("rand%0d", ph));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
